// File: rtl/truth_table_sweeper.sv
// Sweeps a 3-input gate through all 8 input vectors, assembles its truth-table code and compares
// it with an expected code. Define TRUTH_TABLE_SWEEPER_MISMATCH_LOG_EN for mismatch statistics.
module truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic [7:0] i_expected,
  output logic [2:0] o_dut_in,
  input  logic       i_dut_out,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_truth_table,
`ifdef TRUTH_TABLE_SWEEPER_MISMATCH_LOG_EN
  output logic       o_match,
  output logic [3:0] o_mismatch_cnt,
  output logic [2:0] o_first_mismatch_idx
`else
  output logic       o_match
`endif
);

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

  state_e           r_state, w_state_d;
  logic [2:0]       r_idx, w_idx_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic [7:0]       r_exp, w_exp_d;
  logic [7:0]       r_tt, w_tt_d;
  logic             r_match, w_match_d;
  logic [2:0]       r_dut_in, w_dut_in_d;
  logic             r_sync1, r_sync2;
  logic             w_mis;

`ifdef TRUTH_TABLE_SWEEPER_MISMATCH_LOG_EN
  logic [3:0] r_mm_cnt, w_mm_cnt_d;
  logic [2:0] r_mm_first, w_mm_first_d;
`endif

  // The gate output is asynchronous to clk; only r_sync2 is ever sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_dut_out;
      r_sync2 <= r_sync1;
    end
  end

  assign w_mis = r_sync2 ^ r_exp[3'd7 - r_idx];

  always_comb begin
    w_state_d  = r_state;
    w_idx_d    = r_idx;
    w_cnt_d    = r_cnt;
    w_exp_d    = r_exp;
    w_tt_d     = r_tt;
    w_match_d  = r_match;
    w_dut_in_d = r_dut_in;
`ifdef TRUTH_TABLE_SWEEPER_MISMATCH_LOG_EN
    w_mm_cnt_d   = r_mm_cnt;
    w_mm_first_d = r_mm_first;
`endif
    if (r_state != StIdle && i_abort) begin
      // Partial truth table is kept for debug; match is never left asserted.
      w_state_d  = StIdle;
      w_dut_in_d = 3'd0;
      w_idx_d    = 3'd0;
      w_cnt_d    = '0;
      w_match_d  = 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start && !i_abort) begin
            w_exp_d    = i_expected;
            w_tt_d     = 8'h00;
            w_match_d  = 1'b0;
            w_idx_d    = 3'd0;
            w_dut_in_d = 3'd0;
            w_cnt_d    = '0;
            w_state_d  = StSettle;
`ifdef TRUTH_TABLE_SWEEPER_MISMATCH_LOG_EN
            w_mm_cnt_d   = 4'd0;
            w_mm_first_d = 3'd0;
`endif
          end
        end
        StSettle: begin
          w_cnt_d = r_cnt + 1'b1;
          if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
            w_state_d = StSample;
          end
        end
        StSample: begin
          w_tt_d[3'd7 - r_idx] = r_sync2;
`ifdef TRUTH_TABLE_SWEEPER_MISMATCH_LOG_EN
          if (w_mis) begin
            // Vectors are visited in ascending order, so the first hit is the lowest index.
            if (r_mm_cnt == 4'd0) begin
              w_mm_first_d = r_idx;
            end
            w_mm_cnt_d = r_mm_cnt + 4'd1;
          end
`endif
          if (r_idx == 3'd7) begin
            w_match_d = (w_tt_d == r_exp);
            w_state_d = StDone;
          end else begin
            w_idx_d    = r_idx + 3'd1;
            w_dut_in_d = r_idx + 3'd1;
            w_cnt_d    = '0;
            w_state_d  = StSettle;
          end
        end
        StDone: begin
          w_state_d = StIdle;
        end
        default: begin
          w_state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_idx    <= 3'd0;
      r_cnt    <= '0;
      r_exp    <= 8'h00;
      r_tt     <= 8'h00;
      r_match  <= 1'b0;
      r_dut_in <= 3'd0;
    end else begin
      r_state  <= w_state_d;
      r_idx    <= w_idx_d;
      r_cnt    <= w_cnt_d;
      r_exp    <= w_exp_d;
      r_tt     <= w_tt_d;
      r_match  <= w_match_d;
      r_dut_in <= w_dut_in_d;
    end
  end

`ifdef TRUTH_TABLE_SWEEPER_MISMATCH_LOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mm_cnt   <= 4'd0;
      r_mm_first <= 3'd0;
    end else begin
      r_mm_cnt   <= w_mm_cnt_d;
      r_mm_first <= w_mm_first_d;
    end
  end

  assign o_mismatch_cnt       = r_mm_cnt;
  assign o_first_mismatch_idx = r_mm_first;
`else
  logic w_unused_mis;
  assign w_unused_mis = w_mis;
`endif

  assign o_dut_in      = r_dut_in;
  assign o_busy        = (r_state != StIdle);
  assign o_done        = (r_state == StDone);
  assign o_truth_table = r_tt;
  assign o_match       = r_match;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomised bench for truth_table_sweeper: two instances (settle 4 and settle 3) driven by
// behavioural gate models and checked against a cycle-position reference model.
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start4 = 1'b0;
  logic       start3 = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] expected = 8'h00;
  logic [7:0] gcode [2];

  logic [2:0] w_in    [2];
  logic       w_out   [2];
  logic       w_busy  [2];
  logic       w_done  [2];
  logic       w_match [2];
  logic [7:0] w_tt    [2];
`ifdef TRUTH_TABLE_SWEEPER_MISMATCH_LOG_EN
  logic [3:0] w_mmc   [2];
  logic [2:0] w_fmi   [2];
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Gate models: output is bit (7-k) of the gate's code for input vector k.
  assign w_out[0] = gcode[0][3'd7 - w_in[0]];
  assign w_out[1] = gcode[1][3'd7 - w_in[1]];

  truth_table_sweeper #(.SETTLE_CYCLES(4), .CNT_W(8)) u_dut4 (
    .clk                  (clk),
    .rst_n                (rst_n),
    .i_start              (start4),
    .i_abort              (abort),
    .i_expected           (expected),
    .o_dut_in             (w_in[0]),
    .i_dut_out            (w_out[0]),
    .o_busy               (w_busy[0]),
    .o_done               (w_done[0]),
    .o_truth_table        (w_tt[0]),
`ifdef TRUTH_TABLE_SWEEPER_MISMATCH_LOG_EN
    .o_match              (w_match[0]),
    .o_mismatch_cnt       (w_mmc[0]),
    .o_first_mismatch_idx (w_fmi[0])
`else
    .o_match              (w_match[0])
`endif
  );

  truth_table_sweeper #(.SETTLE_CYCLES(3), .CNT_W(8)) u_dut3 (
    .clk                  (clk),
    .rst_n                (rst_n),
    .i_start              (start3),
    .i_abort              (abort),
    .i_expected           (expected),
    .o_dut_in             (w_in[1]),
    .i_dut_out            (w_out[1]),
    .o_busy               (w_busy[1]),
    .o_done               (w_done[1]),
    .o_truth_table        (w_tt[1]),
`ifdef TRUTH_TABLE_SWEEPER_MISMATCH_LOG_EN
    .o_match              (w_match[1]),
    .o_mismatch_cnt       (w_mmc[1]),
    .o_first_mismatch_idx (w_fmi[1])
`else
    .o_match              (w_match[1])
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_mm_cnt(input logic [7:0] code, input logic [7:0] exp);
    logic [3:0] c = 4'd0;
    for (int k = 0; k < 8; k++) if (code[k] != exp[k]) c++;
    return c;
  endfunction

  function automatic logic [2:0] ref_mm_first(input logic [7:0] code, input logic [7:0] exp);
    for (int k = 0; k < 8; k++) if (code[7-k] != exp[7-k]) return 3'(k);
    return 3'd0;
  endfunction

  task automatic drive_start(input int d, input logic v);
    if (d == 1) start3 = v;
    else start4 = v;
  endtask

  task automatic chk_zero(input int d);
    chk("rst_dut_in", 32'(w_in[d]), 0);
    chk("rst_busy", 32'(w_busy[d]), 0);
    chk("rst_done", 32'(w_done[d]), 0);
    chk("rst_tt", 32'(w_tt[d]), 0);
    chk("rst_match", 32'(w_match[d]), 0);
`ifdef TRUTH_TABLE_SWEEPER_MISMATCH_LOG_EN
    chk("rst_mm_cnt", 32'(w_mmc[d]), 0);
    chk("rst_mm_first", 32'(w_fmi[d]), 0);
`endif
  endtask

  // Caller must be at a negedge. Cycle n = 0 is the first cycle after start is accepted.
  task automatic sweep(input int d, input logic [7:0] code, input logic [7:0] exp,
                       input int poke_n, input int abort_n, input int rst_at, input bit hold);
    int s     = (d == 1) ? 3 : 4;
    int per   = s + 1;
    int total = 8 * per;
    int dones = 0;
    int lat   = -1;
    logic [7:0] part;
    gcode[d] = code;
    expected = exp;
    drive_start(d, 1'b1);
    for (int n = 0; n <= total + 2; n++) begin
      @(negedge clk);
      if (n == 0 && !hold) drive_start(d, 1'b0);
      if (w_done[d]) begin
        dones++;
        if (lat < 0) lat = n;
      end
      if (rst_at >= 0 && n == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk_zero(0);
        chk_zero(1);
        chk("rst_no_done", dones, 0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (abort_n >= 0 && n == abort_n + 1) begin
        abort = 1'b0;
        part  = 8'h00;
        for (int k = 0; k < 8; k++) if (k * per + s < abort_n) part[7-k] = code[7-k];
        chk("abort_busy", 32'(w_busy[d]), 0);
        chk("abort_dut_in", 32'(w_in[d]), 0);
        chk("abort_done", 32'(w_done[d]), 0);
        chk("abort_tt", 32'(w_tt[d]), 32'(part));
        chk("abort_match", 32'(w_match[d]), 0);
        repeat (total) begin
          @(negedge clk);
          if (w_done[d]) dones++;
        end
        chk("abort_no_done", dones, 0);
        return;
      end
      if (n < total) begin
        chk("dut_in", 32'(w_in[d]), n / per);
        chk("busy", 32'(w_busy[d]), 1);
      end
      if (n == total) begin
        chk("tt", 32'(w_tt[d]), 32'(code));
        chk("match", 32'(w_match[d]), 32'(code == exp));
`ifdef TRUTH_TABLE_SWEEPER_MISMATCH_LOG_EN
        chk("mm_cnt", 32'(w_mmc[d]), 32'(ref_mm_cnt(code, exp)));
        chk("mm_first", 32'(w_fmi[d]), 32'(ref_mm_first(code, exp)));
`endif
      end
      if (n == total + 1) begin
        chk("idle_busy", 32'(w_busy[d]), 0);
        chk("held_match", 32'(w_match[d]), 32'(code == exp));
      end
      if (hold && n == total + 2) begin
        chk("restart_busy", 32'(w_busy[d]), 1);
        abort = 1'b1;
        drive_start(d, 1'b0);
        @(negedge clk);
        abort = 1'b0;
      end
      if (poke_n >= 0 && n == poke_n) begin
        drive_start(d, 1'b1);
        expected = ~exp;
      end
      if (poke_n >= 0 && n == poke_n + 1) drive_start(d, 1'b0);
      if (abort_n >= 0 && n == abort_n) abort = 1'b1;
    end
    chk("latency", lat + 1, total + 1);
    chk("done_count", dones, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] c;
    logic [7:0] e;
    gcode[0] = 8'h00;
    gcode[1] = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero(0);
    chk_zero(1);

    sweep(0, 8'h59, 8'h59, -1, -1, -1, 1'b0);
    sweep(0, 8'hFF, 8'h59, -1, -1, -1, 1'b0);
    sweep(0, 8'h59, 8'h59, 10, -1, -1, 1'b0);
    sweep(0, 8'hA5, 8'hA5, -1, 16, -1, 1'b0);
    sweep(0, 8'h3C, 8'h3C, -1, -1, -1, 1'b0);
    sweep(0, 8'h96, 8'h96, -1, -1, 12, 1'b0);
    sweep(0, 8'h96, 8'h69, -1, -1, -1, 1'b0);
    sweep(0, 8'hC3, 8'hC3, -1, -1, -1, 1'b1);
    repeat (2) @(negedge clk);

    // abort wins over start in idle
    start4 = 1'b1;
    abort  = 1'b1;
    @(negedge clk);
    chk("abort_start_busy", 32'(w_busy[0]), 0);
    start4 = 1'b0;
    abort  = 1'b0;
    @(negedge clk);
    chk("abort_start_idle", 32'(w_busy[0]), 0);

    sweep(1, 8'h80, 8'h80, -1, -1, -1, 1'b0);
    sweep(1, 8'h01, 8'h80, -1, -1, -1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      c = 8'($urandom);
      e = ($urandom_range(0, 1) == 1) ? c : 8'($urandom);
      sweep(i % 2, c, e, -1, -1, -1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
